alu_mul_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 17 +
 rtl/alu.sv | 51 +++++
 rtl/alu_mul_sequencer.sv | 97 +++++++++
 tb/tb_alu_mul_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU op_code encodings and multiply-sequencer state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_SLT = 3'b011;
    localparam logic [2:0] ALU_ADD = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

endpackage

// File: rtl/alu.sv
// Single-cycle RV32I-style ALU; purely combinational, zero latency, no flow control.
// cry_out is the carry of ADD and the borrow of SUB, zero for other ops.
module alu
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] op1,
    input  logic [N-1:0] op2,
    input  logic [2:0]   op_code,
    output logic [N-1:0] dout,
    output logic         cry_out
);

    localparam int SW = $clog2(N);

    logic [N:0]    sum;
    logic [N:0]    diff;
    logic [SW-1:0] shamt;
    logic          lt;

    always_comb begin
        sum   = {1'b0, op1} + {1'b0, op2};
        diff  = {1'b0, op1} - {1'b0, op2};
        shamt = op2[SW-1:0];
        lt    = $signed(op1) < $signed(op2);
    end

    always_comb begin
        dout    = '0;
        cry_out = 1'b0;
        case (op_code)
            ALU_AND: dout = op1 & op2;
            ALU_OR:  dout = op1 | op2;
            ALU_XOR: dout = op1 ^ op2;
            ALU_SLT: dout = {{(N-1){1'b0}}, lt};
            ALU_ADD: begin
                dout    = sum[N-1:0];
                cry_out = sum[N];
            end
            ALU_SUB: begin
                dout    = diff[N-1:0];
                cry_out = diff[N];
            end
            ALU_SLL: dout = op1 << shamt;
            ALU_SRL: dout = op1 >> shamt;
            default: dout = '0;
        endcase
    end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier that borrows the shared ALU adder for accumulation while busy.
// Latency N+1 cycles from accept to done (fewer with EARLY_EXIT); start ignored while busy.
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int N          = 32,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         flush,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic [N-1:0] alu_op1,
    output logic [N-1:0] alu_op2,
    output logic [2:0]   alu_op_code,
    input  logic [N-1:0] alu_dout
);

    localparam int CW = $clog2(N);

    logic [1:0]    state;
    logic [N-1:0]  acc;
    logic [N-1:0]  mcand;
    logic [N-1:0]  mplier;
    logic [CW-1:0] cnt;
    logic          last;

    // Exit test uses the multiplier bits before this cycle's shift; the final add still happens.
    always_comb begin
        last = (cnt == CW'(N - 1));
        if (EARLY_EXIT && (mplier[N-1:1] == '0)) begin
            last = 1'b1;
        end
    end

    always_comb begin
        alu_op1     = '0;
        alu_op2     = '0;
        alu_op_code = ALU_ADD;
        if (state == RUN) begin
            alu_op1 = acc;
            alu_op2 = mplier[0] ? mcand : '0;
        end
    end

    assign busy = (state == RUN) || (state == DONE);
    assign done = (state == DONE) && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        acc    <= '0;
                        mcand  <= op_a;
                        mplier <= op_b;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc    <= alu_dout;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CW'(1);
                        if (last) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!flush) begin
                        result <= acc;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboarded bench: one sequencer+ALU pair with EARLY_EXIT=0, another with EARLY_EXIT=1.
module tb_alu_mul_sequencer;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        rst0, start0, flush0, busy0, done0, cry0;
    logic [31:0] a0, b0, result0, op1_0, op2_0, dout0;
    logic [2:0]  opc0;
    logic        rst1, start1, flush1, busy1, done1, cry1;
    logic [31:0] a1, b1, result1, op1_1, op2_1, dout1;
    logic [2:0]  opc1;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_mul_sequencer #(.N(32), .EARLY_EXIT(1'b0)) u_seq0 (
        .clk(clk), .rst(rst0), .start(start0), .flush(flush0), .op_a(a0), .op_b(b0),
        .busy(busy0), .done(done0), .result(result0),
        .alu_op1(op1_0), .alu_op2(op2_0), .alu_op_code(opc0), .alu_dout(dout0)
    );
    alu #(.N(32)) u_alu0 (.op1(op1_0), .op2(op2_0), .op_code(opc0), .dout(dout0), .cry_out(cry0));

    alu_mul_sequencer #(.N(32), .EARLY_EXIT(1'b1)) u_seq1 (
        .clk(clk), .rst(rst1), .start(start1), .flush(flush1), .op_a(a1), .op_b(b1),
        .busy(busy1), .done(done1), .result(result1),
        .alu_op1(op1_1), .alu_op2(op2_1), .alu_op_code(opc1), .alu_dout(dout1)
    );
    alu #(.N(32)) u_alu1 (.op1(op1_1), .op2(op2_1), .op_code(opc1), .dout(dout1), .cry_out(cry1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: done cycle is checked on the done cycle, result on the cycle after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done0 === 1'b1) begin
                if (q0.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done0: got done=1, expected none (cycle %0d)", cyc);
                end else begin
                    e = q0.pop_front();
                    check("done0_cycle", cyc, e.cyc);
                    @(negedge clk);
                    check("result0", result0, e.val);
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done1 === 1'b1) begin
                if (q1.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done1: got done=1, expected none (cycle %0d)", cyc);
                end else begin
                    e = q1.pop_front();
                    check("done1_cycle", cyc, e.cyc);
                    @(negedge clk);
                    check("result1", result1, e.val);
                end
            end
        end
    end

    // Called on a negedge; start is high for that cycle, so done is due lat cycles later.
    task automatic issue(input int which, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
        exp_t e;
        e.val = exp;
        e.cyc = cyc + lat;
        if (which == 0) begin
            start0 = 1'b1; a0 = a; b0 = b; q0.push_back(e);
        end else begin
            start1 = 1'b1; a1 = a; b1 = b; q1.push_back(e);
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic drain(input int which);
        int left;
        left = (which == 0) ? q0.size() : q1.size();
        for (int i = 0; i < 200 && left != 0; i++) begin
            @(negedge clk);
            left = (which == 0) ? q0.size() : q1.size();
        end
        if (left != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain%0d_timeout: got %0d pending, expected 0", which, left);
            if (which == 0) q0.delete(); else q1.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int t;
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish by cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        rst0 = 1'b1; rst1 = 1'b1;
        start0 = 1'b0; flush0 = 1'b0; a0 = '0; b0 = '0;
        start1 = 1'b0; flush1 = 1'b0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy0}, 32'd0);
        check("rst_done", {31'b0, done0}, 32'd0);
        check("rst_result", result0, 32'd0);
        check("rst_op1", op1_0, 32'd0);
        check("rst_op2", op2_0, 32'd0);
        check("rst_opcode", {29'b0, opc0}, 32'd4);
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);

        // 7*6 with an ignored start mid-run, then re-accept right after DONE
        t = cyc;
        issue(0, 32'd7, 32'd6, 32'd42, 33);
        check("busy_t1", {31'b0, busy0}, 32'd1);
        while (cyc < t + 4) @(negedge clk);
        start0 = 1'b1; a0 = 32'd100; b0 = 32'd100;
        @(negedge clk);
        start0 = 1'b0;
        while (cyc < t + 34) @(negedge clk);
        issue(0, 32'd3, 32'd4, 32'd12, 33);
        repeat (4) @(negedge clk);
        check("result_hold", result0, 32'd42);
        drain(0);

        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
        drain(0);
        issue(0, 32'h8000_0000, 32'd2, 32'd0, 33);
        drain(0);
        issue(0, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 33);
        drain(0);

        // flush mid-run: back to IDLE, no done, result unchanged
        t = cyc;
        start0 = 1'b1; a0 = 32'd9; b0 = 32'd9;
        @(negedge clk);
        start0 = 1'b0;
        while (cyc < t + 10) @(negedge clk);
        flush0 = 1'b1;
        @(negedge clk);
        flush0 = 1'b0;
        check("flush_busy", {31'b0, busy0}, 32'd0);
        check("flush_result", result0, 32'hFFFE_0001);
        start0 = 1'b1; flush0 = 1'b1; a0 = 32'd2; b0 = 32'd2;
        @(negedge clk);
        start0 = 1'b0; flush0 = 1'b0;
        check("flush_start_busy", {31'b0, busy0}, 32'd0);
        repeat (40) @(negedge clk);
        check("flush_result_late", result0, 32'hFFFE_0001);

        // reset mid-run clears everything, then a fresh op completes
        t = cyc;
        start0 = 1'b1; a0 = 32'd5; b0 = 32'd5;
        @(negedge clk);
        start0 = 1'b0;
        while (cyc < t + 10) @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        check("midrst_busy", {31'b0, busy0}, 32'd0);
        check("midrst_done", {31'b0, done0}, 32'd0);
        check("midrst_result", result0, 32'd0);
        check("midrst_opcode", {29'b0, opc0}, 32'd4);
        issue(0, 32'd11, 32'd13, 32'd143, 33);
        drain(0);

        // EARLY_EXIT instance
        issue(1, 32'd5, 32'd3, 32'd15, 3);
        drain(1);
        issue(1, 32'h0000_1234, 32'd0, 32'd0, 2);
        drain(1);
        issue(1, 32'd1, 32'h8000_0000, 32'h8000_0000, 33);
        drain(1);
        issue(1, 32'h1234_5678, 32'h10, 32'h2345_6780, 6);
        drain(1);

        check("q0_empty", q0.size(), 32'd0);
        check("q1_empty", q1.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
